sw_ctrl: RTL

Sequencing controller for the Smith-Waterman accelerator. It accepts a job on the `start`/`ready` handshake and streams the query and database beats into the PE array's sequence load port. It then clears the array, steps it through every anti-diagonal, waits out the array's pipeline, and captures the maximum local-alignment score with a one-cycle `output_valid` pulse. It sits between the top-level handshake and the PE array datapath.

---
 rtl/sw_pkg.sv | 11 +
 rtl/sw_phase_cnt.sv | 19 +
 rtl/sw_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared state encoding, default widths and beat helper for the Smith-Waterman accelerator.
package sw_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, COMPUTE, FLUSH, DONE} sw_ctrl_state_e;
  localparam int DEF_LETTER_WIDTH = 2;
  localparam int DEF_INPUT_WIDTH = 8;
  localparam int DEF_SCORE_WIDTH = 10;
  localparam int DEF_SEQ_LEN = 32;
  function automatic int letters_per_beat(input int input_width, input int letter_width);
    return input_width / letter_width;
  endfunction
endpackage

// File: rtl/sw_phase_cnt.sv
// sw_phase_cnt: loadable saturating down-counter with terminal-count flag.
module sw_phase_cnt #(
  parameter int W = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= INIT;
    else if (ld) cnt <= ld_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/sw_ctrl.sv
// sw_ctrl: job sequencer for the Smith-Waterman PE array (load, clear, step diagonals, flush, capture).
// Optional SW_CTRL_ABORT_EN adds an abort input that clears the array and returns to idle.
module sw_ctrl import sw_pkg::*; #(
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int LETTER_WIDTH = DEF_LETTER_WIDTH,
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int PE_LAT = 2,
  localparam int LPB = letters_per_beat(INPUT_WIDTH, LETTER_WIDTH),
  localparam int LOAD_BEATS = SEQ_LEN / LPB,
  localparam int DIAGS = 2 * SEQ_LEN - 1,
  localparam int AW = LOAD_BEATS > 1 ? $clog2(LOAD_BEATS) : 1,
  localparam int DW = $clog2(2 * SEQ_LEN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
`ifdef SW_CTRL_ABORT_EN
  input  logic                   abort,
`endif
  input  logic [INPUT_WIDTH-1:0] query_seq_in,
  input  logic [INPUT_WIDTH-1:0] database_seq_in,
  output logic                   ready,
  output logic                   load_we,
  output logic [AW-1:0]          load_addr,
  output logic [INPUT_WIDTH-1:0] load_query_data,
  output logic [INPUT_WIDTH-1:0] load_db_data,
  output logic                   arr_clear,
  output logic                   arr_step,
  output logic [DW-1:0]          arr_diag,
  input  logic [SCORE_WIDTH-1:0] arr_max_score,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   output_valid
);
  localparam int CW = $clog2(DIAGS + LOAD_BEATS + PE_LAT + 1);
  if (INPUT_WIDTH % LETTER_WIDTH != 0 || SEQ_LEN % LPB != 0 || PE_LAT < 1 || SEQ_LEN < 1) begin : g_bad_params
    $error("sw_ctrl: illegal parameter combination");
  end
  sw_ctrl_state_e state, nxt;
  logic [CW-1:0] cnt, ld_val;
  logic tc, ld, dec, sample, abort_go, aborting;
`ifdef SW_CTRL_ABORT_EN
  assign abort_go = abort && state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) aborting <= 1'b0;
    else aborting <= abort_go || (aborting && state != CLEAR);
`else
  assign abort_go = 1'b0;
  assign aborting = 1'b0;
`endif
  // The counter idles at LOAD_BEATS-1 so beat 0 on the start cycle counts as the first load beat.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !start ? IDLE : tc ? CLEAR : LOAD;
      LOAD:    nxt = tc ? CLEAR : LOAD;
      CLEAR:   nxt = aborting ? IDLE : COMPUTE;
      COMPUTE: nxt = tc ? FLUSH : COMPUTE;
      FLUSH:   nxt = tc ? DONE : FLUSH;
      default: nxt = IDLE;
    endcase
    if (abort_go) nxt = CLEAR;
  end
  assign sample = (state == IDLE && start) || (state == LOAD && !abort_go);
  assign ld = nxt != state && (nxt == IDLE || nxt == CLEAR || nxt == FLUSH);
  assign ld_val = nxt == IDLE ? CW'(LOAD_BEATS - 1) : nxt == CLEAR ? CW'(DIAGS - 1) : CW'(PE_LAT - 1);
  assign dec = sample || state == COMPUTE || state == FLUSH;
  assign ready = state == IDLE;
  sw_phase_cnt #(.W(CW), .INIT(CW'(LOAD_BEATS - 1))) u_cnt (
    .clk(clk), .rst_n(rst_n), .ld(ld), .dec(dec), .ld_val(ld_val), .cnt(cnt), .tc(tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      load_we <= 1'b0;
      load_addr <= '0;
      load_query_data <= '0;
      load_db_data <= '0;
      arr_clear <= 1'b0;
      arr_step <= 1'b0;
      arr_diag <= '0;
      score <= '0;
      output_valid <= 1'b0;
    end else begin
      state <= nxt;
      load_we <= sample;
      if (sample) begin
        load_addr <= AW'(LOAD_BEATS - 1 - int'(cnt));
        load_query_data <= query_seq_in;
        load_db_data <= database_seq_in;
      end
      arr_clear <= nxt == CLEAR;
      arr_step <= nxt == COMPUTE;
      arr_diag <= nxt != COMPUTE ? '0 : state == COMPUTE ? arr_diag + 1'b1 : '0;
      output_valid <= state == DONE && !abort_go;
      if (state == DONE && !abort_go) score <= arr_max_score;
    end
endmodule
